// File: rtl/forwarder_n_pkg.sv
// rtl/forwarder_n_pkg.sv - shared word layout, gap code and forwarder state enumeration
package forwarder_n_pkg;

    localparam int WORD_W  = 72;
    localparam int DATA_W  = 64;
    localparam int CTRL_HI = 71;
    localparam int CTRL_LO = 64;
    localparam int MAC_W   = 48;

    localparam logic [7:0] GAP_CTRL = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        LOOKUP,
        REPLAY0,
        REPLAY1,
        STREAM,
        DROP
    } fwd_state_t;

    // A word whose control byte is the gap code separates frames.
    function automatic logic is_gap(input logic [WORD_W-1:0] word);
        return word[CTRL_HI:CTRL_LO] == GAP_CTRL;
    endfunction

endpackage

// File: rtl/forwarder_hdr_buf.sv
// rtl/forwarder_hdr_buf.sv - two-word header latch and MAC address extraction
module forwarder_hdr_buf
    import forwarder_n_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load0,
    input  logic              load1,
    input  logic [WORD_W-1:0] din,
    output logic [WORD_W-1:0] word0,
    output logic [WORD_W-1:0] word1,
    output logic [MAC_W-1:0]  dest_mac,
    output logic [MAC_W-1:0]  src_mac
);

    // Capture the first two words of a frame; they are replayed after the lookup.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word0 <= '0;
            word1 <= '0;
        end else begin
            if (load0) word0 <= din;
            if (load1) word1 <= din;
        end
    end

    // Addresses come straight from the latched words, so they stay put during the lookup.
    assign dest_mac = word0[DATA_W-1:16];
    assign src_mac  = {word0[15:0], word1[DATA_W-1:32]};

endmodule

// File: rtl/forwarder_n.sv
// rtl/forwarder_n.sv - frame forwarder from one FWFT ingress to an N-port egress set
module forwarder_n
    import forwarder_n_pkg::*;
#(
    parameter int NPORT     = 5,
    parameter int PORT      = 0,
    parameter int LOOKUP_TO = 64
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic [WORD_W-1:0]       dout,
    input  logic                    empty,
    output logic                    rd_en,
    output logic [NPORT*WORD_W-1:0] port_din,
    input  logic [NPORT-1:0]        port_full,
    input  logic [NPORT-1:0]        port_half,
    output logic [NPORT-1:0]        port_wr_en,
    output logic                    req,
    output logic [MAC_W-1:0]        dest_mac,
    output logic [MAC_W-1:0]        src_mac,
    input  logic                    ack,
    input  logic [NPORT-1:0]        forward_port,
    output logic [31:0]             frames_fwd,
    output logic [31:0]             frames_drop
);

    localparam int TMR_W = $clog2(LOOKUP_TO + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(LOOKUP_TO - 1);
    localparam logic [NPORT-1:0] SELF_MASK = NPORT'(1) << PORT;

    fwd_state_t        state;
    logic [NPORT-1:0]  target;
    logic [TMR_W-1:0]  timer;
    logic              resync;
    logic              drop_count;

    logic              blocked;
    logic              in_gap;
    logic              write_ok;
    logic [NPORT-1:0]  ack_target;
    logic [WORD_W-1:0] out_word;
    logic [WORD_W-1:0] word0;
    logic [WORD_W-1:0] word1;
    logic              load0;
    logic              load1;

    // Pop/write decisions; all gated by reset so outputs drop to zero immediately.
    always_comb begin
        blocked    = |(port_full & target);
        in_gap     = is_gap(dout);
        ack_target = forward_port & ~SELF_MASK;
        rd_en      = 1'b0;
        write_ok   = 1'b0;
        out_word   = '0;
        if (!sys_rst) begin
            case (state)
                IDLE, HDR1, DROP: rd_en = !empty;
                REPLAY0: begin
                    write_ok = !blocked;
                    out_word = word0;
                end
                REPLAY1: begin
                    write_ok = !blocked;
                    out_word = word1;
                end
                STREAM: begin
                    rd_en    = !empty && !blocked;
                    write_ok = !empty && !blocked;
                    out_word = dout;
                end
                default: ;
            endcase
        end
    end

    // Every target sees the same word on the same cycle, which keeps multicast lock-step.
    assign port_wr_en = write_ok ? target : '0;
    assign port_din   = {NPORT{out_word}};

    assign load0 = rd_en && (state == IDLE) && !in_gap && !resync;
    assign load1 = rd_en && (state == HDR1) && !in_gap;

    forwarder_hdr_buf u_hdr_buf (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .load0    (load0),
        .load1    (load1),
        .din      (dout),
        .word0    (word0),
        .word1    (word1),
        .dest_mac (dest_mac),
        .src_mac  (src_mac)
    );

    // Frame sequencing, lookup handshake and statistics.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state       <= IDLE;
            target      <= '0;
            timer       <= '0;
            req         <= 1'b0;
            resync      <= 1'b1;
            drop_count  <= 1'b0;
            frames_fwd  <= '0;
            frames_drop <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_en) begin
                        if (in_gap) begin
                            resync <= 1'b0;
                        end else if (resync) begin
                            // Tail of a frame cut off by reset: discard silently.
                            drop_count <= 1'b0;
                            state      <= DROP;
                        end else begin
                            state <= HDR1;
                        end
                    end
                end
                HDR1: begin
                    if (rd_en) begin
                        if (in_gap) begin
                            frames_drop <= frames_drop + 32'd1;
                            state       <= IDLE;
                        end else begin
                            req    <= 1'b1;
                            timer  <= '0;
                            target <= '0;
                            state  <= LOOKUP;
                        end
                    end
                end
                LOOKUP: begin
                    if (ack) begin
                        req    <= 1'b0;
                        target <= ack_target;
                        if ((ack_target == '0) || (|(port_half & ack_target))) begin
                            drop_count <= 1'b1;
                            state      <= DROP;
                        end else begin
                            state <= REPLAY0;
                        end
                    end else if (timer == TMR_LAST) begin
                        req        <= 1'b0;
                        drop_count <= 1'b1;
                        state      <= DROP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                REPLAY0: if (!blocked) state <= REPLAY1;
                REPLAY1: if (!blocked) state <= STREAM;
                STREAM: begin
                    if (rd_en && in_gap) begin
                        frames_fwd <= frames_fwd + 32'd1;
                        state      <= IDLE;
                    end
                end
                DROP: begin
                    if (rd_en && in_gap) begin
                        if (drop_count) frames_drop <= frames_drop + 32'd1;
                        resync <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_forwarder_n.sv
// tb/tb_forwarder_n.sv - self-checking bench for forwarder_n
module tb_forwarder_n;

    localparam int NP = 5;
    localparam int TO = 64;

    logic             sys_clk = 1'b0;
    logic             sys_rst;
    logic [71:0]      dout;
    logic             empty;
    logic             rd_en;
    logic [NP*72-1:0] port_din;
    logic [NP-1:0]    port_full;
    logic [NP-1:0]    port_half;
    logic [NP-1:0]    port_wr_en;
    logic             req;
    logic [47:0]      dest_mac;
    logic [47:0]      src_mac;
    logic             ack;
    logic [NP-1:0]    forward_port;
    logic [31:0]      frames_fwd;
    logic [31:0]      frames_drop;

    forwarder_n #(.NPORT(NP), .PORT(0), .LOOKUP_TO(TO)) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .dout         (dout),
        .empty        (empty),
        .rd_en        (rd_en),
        .port_din     (port_din),
        .port_full    (port_full),
        .port_half    (port_half),
        .port_wr_en   (port_wr_en),
        .req          (req),
        .dest_mac     (dest_mac),
        .src_mac      (src_mac),
        .ack          (ack),
        .forward_port (forward_port),
        .frames_fwd   (frames_fwd),
        .frames_drop  (frames_drop)
    );

    always #5 sys_clk = ~sys_clk;

    int            checks = 0;
    int            failures = 0;
    logic [71:0]   fifo[$];
    logic [71:0]   got[NP][$];
    logic [71:0]   exp_q[NP][$];
    logic [71:0]   frame_w[$];
    logic [71:0]   frame_gap;
    logic [NP-1:0] forced_full = '0;
    bit            full_noise = 1'b0;
    logic [NP-1:0] cur_target = '0;
    int            exp_fwd = 0;
    int            exp_drop = 0;
    bit            req_seen = 1'b0;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Ingress FIFO model and egress collector; samples just before the active edge.
    initial begin
        dout = '0;
        empty = 1'b1;
        port_full = '0;
        forever begin
            @(negedge sys_clk);
            port_full = forced_full | (full_noise ? NP'($urandom) : '0);
            if (fifo.size() > 0 && $urandom_range(0, 4) != 0) begin
                dout = fifo[0];
                empty = 1'b0;
            end else begin
                dout = {8'($urandom), 32'($urandom), 32'($urandom)};
                empty = 1'b1;
            end
            #3;
            if (sys_rst === 1'b0) begin
                if (port_wr_en !== '0) begin
                    check("wr_lockstep", 72'(port_wr_en), 72'(cur_target));
                    check("wr_while_full", 72'(port_wr_en & port_full), 72'(0));
                    for (int i = 0; i < NP; i++)
                        if (port_wr_en[i]) got[i].push_back(port_din[i*72 +: 72]);
                end
                if (rd_en === 1'b1) begin
                    check("pop_when_empty", 72'(empty), 72'(0));
                    if (!empty) void'(fifo.pop_front());
                end
                if (req === 1'b1) req_seen = 1'b1;
            end
        end
    end

    task automatic make_frame(input int len, input logic [47:0] dmac, output logic [47:0] smac);
        smac = {16'($urandom), 32'($urandom)};
        frame_w.delete();
        frame_w.push_back({8'($urandom_range(1, 255)), dmac, smac[47:32]});
        if (len > 1) frame_w.push_back({8'($urandom_range(1, 255)), smac[31:0], 32'($urandom)});
        for (int k = 2; k < len; k++)
            frame_w.push_back({8'($urandom_range(1, 255)), 32'($urandom), 32'($urandom)});
        frame_gap = {8'h00, 32'($urandom), 32'($urandom)};
        fifo.push_back({8'h00, 64'h0});
        foreach (frame_w[k]) fifo.push_back(frame_w[k]);
        fifo.push_back(frame_gap);
    endtask

    task automatic wait_req(output bit ok);
        int n = 0;
        while (req !== 1'b1 && n < 400) begin
            @(negedge sys_clk);
            n++;
        end
        ok = (req === 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        while (fifo.size() != 0 && n < 3000) begin
            @(negedge sys_clk);
            n++;
        end
        repeat (3) @(negedge sys_clk);
        check("fifo_drained", 72'(fifo.size()), 72'(0));
    endtask

    task automatic run_frame(input int len, input logic [47:0] dmac, input bit do_ack,
                             input logic [NP-1:0] fwd, input logic [NP-1:0] half, input int stall);
        logic [47:0]   smac;
        logic [NP-1:0] tgt;
        bit            fwd_ok;
        bit            ok;
        int            n;
        for (int i = 0; i < NP; i++) begin
            got[i].delete();
            exp_q[i].delete();
        end
        req_seen = 1'b0;
        cur_target = '0;
        make_frame(len, dmac, smac);
        tgt = fwd & ~NP'(1);
        fwd_ok = do_ack && (len > 1) && (tgt != '0) && ((half & tgt) == '0);
        for (int i = 0; i < NP; i++) begin
            if (fwd_ok && tgt[i]) begin
                foreach (frame_w[k]) exp_q[i].push_back(frame_w[k]);
                exp_q[i].push_back(frame_gap);
            end
        end
        if (fwd_ok) exp_fwd++;
        else exp_drop++;

        if (len > 1) begin
            wait_req(ok);
            check("req_rise", 72'(ok), 72'(1));
            check("dest_mac", 72'(dest_mac), 72'(dmac));
            check("src_mac", 72'(src_mac), 72'(smac));
            if (do_ack) begin
                repeat ($urandom_range(0, 5)) @(negedge sys_clk);
                check("req_held", 72'(req), 72'(1));
                check("dest_mac_held", 72'(dest_mac), 72'(dmac));
                cur_target = fwd_ok ? tgt : '0;
                port_half = half;
                forward_port = fwd;
                ack = 1'b1;
                @(negedge sys_clk);
                ack = 1'b0;
                port_half = '0;
                forward_port = NP'($urandom);
                check("req_after_ack", 72'(req), 72'(0));
            end else begin
                n = 0;
                while (req === 1'b1 && n < 300) begin
                    n++;
                    @(negedge sys_clk);
                end
                check("req_timeout_cycles", 72'(n), 72'(TO));
                forward_port = 5'b11110;
                ack = 1'b1;
                @(negedge sys_clk);
                ack = 1'b0;
            end
            if (stall > 0) begin
                n = 0;
                while (got[1].size() < 3 && n < 500) begin
                    @(negedge sys_clk);
                    n++;
                end
                check("stall_reached_stream", 72'(got[1].size() >= 3), 72'(1));
                @(posedge sys_clk);
                #1 forced_full = 5'b00100;
                for (int c = 0; c < stall; c++) begin
                    @(negedge sys_clk);
                    #3;
                    check($sformatf("stall_rd_en_c%0d", c), 72'(rd_en), 72'(0));
                    check($sformatf("stall_wr_en_c%0d", c), 72'(port_wr_en), 72'(0));
                end
                @(posedge sys_clk);
                #1 forced_full = '0;
            end
        end
        drain();
        if (len == 1) check("runt_no_req", 72'(req_seen), 72'(0));
        check("frames_fwd", 72'(frames_fwd), 72'(exp_fwd));
        check("frames_drop", 72'(frames_drop), 72'(exp_drop));
        for (int i = 0; i < NP; i++) begin
            check($sformatf("port%0d_count", i), 72'(got[i].size()), 72'(exp_q[i].size()));
            for (int k = 0; k < got[i].size() && k < exp_q[i].size(); k++)
                check($sformatf("port%0d_word%0d", i, k), got[i][k], exp_q[i][k]);
        end
    endtask

    initial begin
        logic [47:0]   smac;
        logic [NP-1:0] f;
        bit            ok;
        int            n;
        sys_rst = 1'b1;
        ack = 1'b0;
        forward_port = '0;
        port_half = '0;
        fifo.push_back({8'h00, 64'h0});
        repeat (3) @(negedge sys_clk);
        #3;
        check("rst_rd_en", 72'(rd_en), 72'(0));
        check("rst_wr_en", 72'(port_wr_en), 72'(0));
        check("rst_req", 72'(req), 72'(0));
        check("rst_port_din", 72'(|port_din), 72'(0));
        check("rst_dest_mac", 72'(dest_mac), 72'(0));
        check("rst_src_mac", 72'(src_mac), 72'(0));
        check("rst_frames_fwd", 72'(frames_fwd), 72'(0));
        check("rst_frames_drop", 72'(frames_drop), 72'(0));
        @(negedge sys_clk);
        sys_rst = 1'b0;

        run_frame(4, 48'h00a0de1c07e8, 1'b1, 5'b00010, 5'b00000, 0);
        full_noise = 1'b1;
        run_frame(6, {16'($urandom), 32'($urandom)}, 1'b1, 5'b11111, 5'b00000, 0);
        full_noise = 1'b0;
        run_frame(14, {16'($urandom), 32'($urandom)}, 1'b1, 5'b00110, 5'b00000, 10);
        run_frame(5, {16'($urandom), 32'($urandom)}, 1'b0, 5'b00000, 5'b00000, 0);
        run_frame(4, {16'($urandom), 32'($urandom)}, 1'b1, 5'b01000, 5'b01000, 0);
        run_frame(1, {16'($urandom), 32'($urandom)}, 1'b1, 5'b00010, 5'b00000, 0);
        run_frame(3, {16'($urandom), 32'($urandom)}, 1'b1, 5'b00001, 5'b00000, 0);
        full_noise = 1'b1;
        for (int r = 0; r < 5; r++) begin
            f = NP'($urandom);
            run_frame($urandom_range(2, 8), {16'($urandom), 32'($urandom)}, 1'b1, f,
                      ($urandom_range(0, 3) == 0) ? NP'($urandom) : '0, 0);
        end
        full_noise = 1'b0;

        for (int i = 0; i < NP; i++) got[i].delete();
        make_frame(12, 48'h0123456789ab, smac);
        wait_req(ok);
        check("rstseq_req", 72'(ok), 72'(1));
        forward_port = 5'b00010;
        ack = 1'b1;
        cur_target = 5'b00010;
        @(negedge sys_clk);
        ack = 1'b0;
        n = 0;
        while (got[1].size() < 4 && n < 500) begin
            @(negedge sys_clk);
            n++;
        end
        check("rstseq_in_stream", 72'(got[1].size() >= 4), 72'(1));
        sys_rst = 1'b1;
        #1;
        check("rstseq_rd_en", 72'(rd_en), 72'(0));
        check("rstseq_wr_en", 72'(port_wr_en), 72'(0));
        check("rstseq_req", 72'(req), 72'(0));
        check("rstseq_port_din", 72'(|port_din), 72'(0));
        check("rstseq_frames_fwd", 72'(frames_fwd), 72'(0));
        check("rstseq_dest_mac", 72'(dest_mac), 72'(0));
        exp_fwd = 0;
        exp_drop = 0;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        req_seen = 1'b0;
        drain();
        check("rstseq_no_req", 72'(req_seen), 72'(0));
        check("rstseq_frames_drop", 72'(frames_drop), 72'(0));
        check("rstseq_frames_fwd_after", 72'(frames_fwd), 72'(0));
        run_frame(5, {16'($urandom), 32'($urandom)}, 1'b1, 5'b00110, 5'b00000, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
